mem_access_unit: RTL and testbench

Load/store unit on the memory side of the CPU datapath. It takes the address produced by the datapath's `datapath_out` and the store data from its `str_data` read port, and runs one word or byte access against data memory over a req/ack handshake. For loads it returns the result to the register file's dedicated load write port (`w_en_ldr` / `w_addr_ldr` / `w_data_ldr`). It holds `req_ready` low while an access is in flight so the controller can stall.

---
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: runs one word or byte access per request against data memory
// over a req/ack handshake and returns load results to the register-file load port.
module mem_access_unit #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_byte,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_rd,
  output logic              w_en_ldr,
  output logic [3:0]        w_addr_ldr,
  output logic [31:0]       w_data_ldr,
  output logic              done,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state_q, state_d;
  logic                load_q, load_d;
  logic                byte_q, byte_d;
  logic [1:0]          lane_q, lane_d;
  logic [3:0]          rd_q, rd_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                w_en_q, w_en_d;
  logic [3:0]          w_addr_q, w_addr_d;
  logic [31:0]         w_data_q, w_data_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;
  logic [31:0]         rdata_shifted;
  logic [31:0]         load_data;
  logic                misaligned;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign misaligned    = !req_byte && (req_addr[1:0] != 2'b00);
  assign rdata_shifted = mem_rdata >> {lane_q, 3'b000};
  assign load_data     = byte_q ? {24'h0, rdata_shifted[7:0]} : mem_rdata;

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    byte_d      = byte_q;
    lane_d      = lane_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    w_en_d      = w_en_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    done_d      = done_q;
    fault_d     = fault_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          load_d = req_load;
          byte_d = req_byte;
          lane_d = req_addr[1:0];
          rd_d   = req_rd;
          // A misaligned word access never reaches memory; it reports directly.
          if (misaligned) begin
            state_d = RESP;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_we_d   = !req_load;
            mem_addr_d = req_addr[ADDR_W+1:2];
            mem_be_d   = (req_load || !req_byte) ? 4'hF : (4'b0001 << req_addr[1:0]);
            if (req_load)
              mem_wdata_d = 32'h0;
            else if (req_byte)
              mem_wdata_d = {4{req_wdata[7:0]}};
            else
              mem_wdata_d = req_wdata;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = 4'h0;
          mem_wdata_d = 32'h0;
          done_d      = 1'b1;
          if (load_q) begin
            w_en_d   = 1'b1;
            w_addr_d = rd_q;
            w_data_d = load_data;
          end
        end
      end
      RESP: begin
        state_d  = IDLE;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        w_en_d   = 1'b0;
        w_addr_d = 4'h0;
        w_data_d = 32'h0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      load_q      <= 1'b0;
      byte_q      <= 1'b0;
      lane_q      <= 2'b00;
      rd_q        <= 4'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      w_en_q      <= 1'b0;
      w_addr_q    <= 4'h0;
      w_data_q    <= 32'h0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      byte_q      <= byte_d;
      lane_q      <= lane_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      w_en_q      <= w_en_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign w_en_ldr   = w_en_q;
  assign w_addr_ldr = w_addr_q;
  assign w_data_ldr = w_data_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected responses are queued when a request
// is driven and compared when the unit signals done.
module tb_mem_access_unit;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_load, req_byte;
  logic [31:0]       req_addr, req_wdata;
  logic [3:0]        req_rd;
  logic              w_en_ldr;
  logic [3:0]        w_addr_ldr;
  logic [31:0]       w_data_ldr;
  logic              done, fault;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  typedef struct packed {
    logic        wen;
    logic [3:0]  rd;
    logic [31:0] data;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   req_cycles = 0;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .w_en_ldr(w_en_ldr), .w_addr_ldr(w_addr_ldr), .w_data_ldr(w_data_ldr),
    .done(done), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (mem_req) req_cycles <= req_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic bt, input logic [1:0] lane,
                                           input logic [31:0] rdata);
    if (!bt) return rdata;
    case (lane)
      2'd0:    return {24'h0, rdata[7:0]};
      2'd1:    return {24'h0, rdata[15:8]};
      2'd2:    return {24'h0, rdata[23:16]};
      default: return {24'h0, rdata[31:24]};
    endcase
  endfunction

  // Called at the negedge of the cycle where done is expected.
  task automatic check_resp(input string tag);
    exp_t e;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'(sb.size()));
    end else begin
      e = sb.pop_front();
      chk({tag, ".fault"}, 32'(fault), 32'(e.flt));
      chk({tag, ".w_en"}, 32'(w_en_ldr), 32'(e.wen));
      if (e.wen) begin
        chk({tag, ".w_addr"}, 32'(w_addr_ldr), 32'(e.rd));
        chk({tag, ".w_data"}, w_data_ldr, e.data);
      end
    end
  endtask

  task automatic access(input string tag, input logic ld, input logic bt,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] rd, input int waits, input logic [31:0] rdata);
    logic        mis;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    int          rc0;
    exp_t        e;
    mis = !bt && (addr[1:0] != 2'b00);
    ebe = (ld || !bt) ? 4'hF : (4'b0001 << addr[1:0]);
    ewd = bt ? {4{wdata[7:0]}} : wdata;
    @(negedge clk);
    chk({tag, ".ready_pre"}, 32'(req_ready), 32'd1);
    rc0 = req_cycles;
    req_valid = 1'b1; req_load = ld; req_byte = bt;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    e.wen = ld && !mis; e.rd = rd; e.flt = mis;
    e.data = exp_load(bt, addr[1:0], rdata);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (!mis) begin
      for (int i = 0; i <= waits; i++) begin
        chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(!ld));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr[ADDR_W+1:2]));
        chk({tag, ".mem_be"}, 32'(mem_be), 32'(ebe));
        if (!ld) chk({tag, ".mem_wdata"}, mem_wdata, ewd);
        chk({tag, ".done_early"}, 32'(done), 32'd0);
        mem_ack   = (i == waits);
        mem_rdata = (i == waits) ? rdata : ~rdata;
        @(negedge clk);
      end
      mem_ack = 1'b0;
    end
    check_resp(tag);
    if (mis) chk({tag, ".no_mem_req"}, 32'(req_cycles), 32'(rc0));
    @(negedge clk);
    chk({tag, ".ready_post"}, 32'(req_ready), 32'd1);
    chk({tag, ".done_post"}, 32'(done), 32'd0);
    $display("txn %s: ld=%0d byte=%0d addr=%h rd=%0d waits=%0d", tag, ld, bt, addr, rd, waits);
  endtask

  initial begin
    int   base;
    exp_t e;
    rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_byte = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 4'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.w_en", 32'(w_en_ldr), 32'd0);
    chk("rst.w_data", w_data_ldr, 32'h0);
    chk("rst.mem_addr", 32'(mem_addr), 32'h0);
    chk("rst.mem_be", 32'(mem_be), 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    access("ldr_w0",    1'b1, 1'b0, 32'h0000_0040, 32'h0,          4'd3,  0, 32'hDEAD_BEEF);
    access("strb_l2",   1'b0, 1'b1, 32'h0000_0102, 32'h1234_56AB,  4'd7,  0, 32'h0);
    access("ldrb_l3",   1'b1, 1'b1, 32'h0000_0007, 32'h0,          4'd4,  3, 32'h89AB_CDEF);
    access("ldr_mis",   1'b1, 1'b0, 32'h0000_0041, 32'h0,          4'd2,  0, 32'h5555_5555);
    access("str_mis",   1'b0, 1'b0, 32'h0000_0082, 32'hCAFE_F00D,  4'd2,  0, 32'h0);
    access("str_w1",    1'b0, 1'b0, 32'h0000_0200, 32'hA5A5_0F0F,  4'd0,  1, 32'h0);
    access("ldrb_l1",   1'b1, 1'b1, 32'h0000_0001, 32'h0,          4'd15, 0, 32'h1122_3344);
    access("strb_l0",   1'b0, 1'b1, 32'h0000_0010, 32'h0000_00C3,  4'd1,  2, 32'h0);
    access("ldr_hi",    1'b1, 1'b0, 32'hFFFF_F04C, 32'h0,          4'd15, 1, 32'h0BAD_F00D);

    // req_valid held high across two accesses: exactly one is taken per ready window.
    @(negedge clk);
    base = req_cycles;
    req_valid = 1'b1; req_load = 1'b0; req_byte = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0000_1111; req_rd = 4'd0;
    e = '{wen: 1'b0, rd: 4'd0, data: 32'h0, flt: 1'b0};
    sb.push_back(e);
    sb.push_back(e);
    @(negedge clk);
    chk("busy.req1", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("busy.ready_in_resp", 32'(req_ready), 32'd0);
    check_resp("busy.resp1");
    @(negedge clk);
    chk("busy.window", 32'(req_ready), 32'd1);
    chk("busy.idle_no_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("busy.req2", 32'(mem_req), 32'd1);
    req_valid = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_resp("busy.resp2");
    @(negedge clk);
    chk("busy.req_cycles", 32'(req_cycles - base), 32'd2);
    $display("txn busy: two held-valid stores, %0d req cycles", req_cycles - base);

    // Stray ack while idle.
    base = done_cnt;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    chk("stray.ready", 32'(req_ready), 32'd1);
    chk("stray.mem_req", 32'(mem_req), 32'd0);
    chk("stray.w_en", 32'(w_en_ldr), 32'd0);
    chk("stray.done_cnt", 32'(done_cnt), 32'(base));
    $display("txn stray_ack: idle ack ignored");

    // Reset in the second REQ cycle of a load.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_byte = 1'b0;
    req_addr = 32'h80; req_rd = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid.req_c1", 32'(mem_req), 32'd1);
    @(posedge clk);
    #2;
    chk("rstmid.req_c2", 32'(mem_req), 32'd1);
    base = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstmid.mem_req", 32'(mem_req), 32'd0);
    chk("rstmid.ready", 32'(req_ready), 32'd1);
    chk("rstmid.w_en", 32'(w_en_ldr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid.no_done", 32'(done_cnt), 32'(base));
    chk("rstmid.ready_after", 32'(req_ready), 32'd1);
    $display("txn reset_mid: access aborted");
    access("ldr_after", 1'b1, 1'b0, 32'h0000_0084, 32'h0, 4'd6, 0, 32'h7654_3210);

    chk("sb.drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
